// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: serialises {rw, addr[6:0], data[7:0]} MSB first on nCS/SCLK/COPI.
// Optional request address check enabled by defining SPI_CTRL_ADDR_CHECK_EN.
module spi_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned CS_HOLD    = 4,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned MAX_ADDR   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD)
                                    ? ((CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES)
                                    : ((CS_HOLD > GAP_CYCLES) ? CS_HOLD : GAP_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  // Reject parameter sets the receiver timing cannot tolerate.
  if (CLK_DIV < 3 || CS_SETUP < 2 || CS_HOLD < 1 || GAP_CYCLES < 4 || MAX_ADDR > 127) begin : g_bad_cfg
    $error("spi_controller: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_REJECT
  } state_t;

  state_t               state, state_d;
  logic [TMR_W-1:0]     tmr, tmr_d;
  logic [DIV_W-1:0]     div, div_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [FRAME_W-1:0]   sr, sr_d;
  logic                 ncs_d, sclk_d, copi_d, ready_d, busy_d, done_d, err_d;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      div       <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      tmr       <= tmr_d;
      div       <= div_d;
      bit_cnt   <= bit_cnt_d;
      sr        <= sr_d;
      nCS       <= ncs_d;
      SCLK      <= sclk_d;
      COPI      <= copi_d;
      req_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d   = state;
    tmr_d     = tmr;
    div_d     = div;
    bit_cnt_d = bit_cnt;
    sr_d      = sr;
    ncs_d     = nCS;
    sclk_d    = SCLK;
    copi_d    = COPI;
    ready_d   = req_ready;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && req_ready) begin
          ready_d = 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
          if (req_write && (req_addr > ADDR_W'(MAX_ADDR))) begin
            err_d   = 1'b1;
            state_d = S_REJECT;
          end else begin
`else
          begin
`endif
            ncs_d   = 1'b0;
            copi_d  = req_write;
            sr_d    = {req_addr, req_data, 1'b0};
            busy_d  = 1'b1;
            tmr_d   = '0;
            state_d = S_SETUP;
          end
        end
      end

      S_REJECT: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      S_SETUP: begin
        if (tmr == TMR_W'(CS_SETUP - 1)) begin
          sclk_d    = 1'b1;
          div_d     = '0;
          bit_cnt_d = BIT_W'(1);
          state_d   = S_SHIFT;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      // Each bit is a full high phase followed by a full low phase; COPI moves only on the fall.
      S_SHIFT: begin
        if (div == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (SCLK) begin
            sclk_d = 1'b0;
            if (bit_cnt != BIT_W'(FRAME_W)) begin
              copi_d = sr[FRAME_W-1];
              sr_d   = {sr[FRAME_W-2:0], 1'b0};
            end
          end else if (bit_cnt == BIT_W'(FRAME_W)) begin
            tmr_d   = '0;
            state_d = S_HOLD;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_d = div + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (tmr == TMR_W'(CS_HOLD - 1)) begin
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          tmr_d   = '0;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      S_GAP: begin
        if (tmr == TMR_W'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed self-checking bench for spi_controller with a bus-level SPI receiver model.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       nCS, SCLK, COPI, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  spi_controller dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .nCS       (nCS),
    .SCLK      (SCLK),
    .COPI      (COPI),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Receiver model and protocol watchers, sampled on the falling clk edge.
  logic [7:0]  regs [0:127];
  logic [15:0] rx_sr = '0;
  logic [15:0] last_frame = '0;
  int rx_cnt = 0, last_bits = 0, low_len = 0, last_low = 0, high_len = 0, last_gap = 0;
  int frames_started = 0, done_cnt = 0, err_cnt = 0;
  int copi_bad = 0, sclk_bad = 0, done_bad = 0;
  logic prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (SCLK && !prev_sclk && !nCS) begin
        rx_sr = {rx_sr[14:0], COPI};
        rx_cnt++;
      end
      if (SCLK && prev_sclk && (COPI !== prev_copi)) copi_bad++;
      if (nCS && SCLK) sclk_bad++;
      if (done && !(nCS && !prev_ncs)) done_bad++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!nCS && prev_ncs) begin
        last_gap = high_len;
        rx_cnt = 0;
        rx_sr = '0;
        low_len = 0;
        frames_started++;
      end
      if (nCS && !prev_ncs) begin
        last_frame = rx_sr;
        last_bits = rx_cnt;
        last_low = low_len;
        high_len = 0;
        if (rx_cnt == 16 && rx_sr[15]) regs[rx_sr[14:8]] = rx_sr[7:0];
      end
      if (!nCS) low_len++;
      else high_len++;
    end
    prev_ncs = nCS;
    prev_sclk = SCLK;
    prev_copi = COPI;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for ready, present one request, retire it on the accepting edge.
  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'(1'b1));
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int n_exp);
    int n;
    n = 0;
    while ((done_cnt - start) < n_exp && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("done_count", 32'(done_cnt - start), 32'(n_exp));
  endtask

  logic [7:0] qd [3];
  int d0, f0, n;

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    qd[0] = 8'hFF;
    qd[1] = 8'h0F;
    qd[2] = 8'hA5;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ncs",   32'(nCS),       32'(1'b1));
    check("rst_sclk",  32'(SCLK),      32'(1'b0));
    check("rst_copi",  32'(COPI),      32'(1'b0));
    check("rst_ready", 32'(req_ready), 32'(1'b0));
    check("rst_busy",  32'(busy),      32'(1'b0));
    check("rst_done",  32'(done),      32'(1'b0));
    check("rst_err",   32'(err),       32'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'(1'b1));
    repeat (5) @(negedge clk);

    // Single write addr 4 data 0x80
    d0 = done_cnt;
    issue(1'b1, 7'd4, 8'h80);
    @(negedge clk);
    check("acc_ncs",   32'(nCS),       32'(1'b0));
    check("acc_copi",  32'(COPI),      32'(1'b1));
    check("acc_sclk",  32'(SCLK),      32'(1'b0));
    check("acc_busy",  32'(busy),      32'(1'b1));
    check("acc_ready", 32'(req_ready), 32'(1'b0));
    wait_done(d0, 1);
    check("w4_frame", 32'(last_frame), 32'h8480);
    check("w4_bits",  32'(last_bits),  32'd16);
    check("w4_reg",   32'(regs[4]),    32'h80);
    check("w4_ncs_low", 32'(last_low), 32'd136);

    // Three back-to-back requests with req_valid held
    d0 = done_cnt;
    f0 = frames_started;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_write = 1'b1;
      req_addr  = 7'(i);
      req_data  = qd[i];
      n = 0;
      while (!req_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("q_ready", 32'(req_ready), 32'(1'b1));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_done(d0, 3);
    check("q_frames", 32'(frames_started - f0), 32'd3);
    check("q_reg0", 32'(regs[0]), 32'hFF);
    check("q_reg1", 32'(regs[1]), 32'h0F);
    check("q_reg2", 32'(regs[2]), 32'hA5);
    check("q_last_frame", 32'(last_frame), 32'h82A5);
    check("q_gap_ge8", 32'(last_gap >= 8), 32'd1);
    check("q_ncs_low", 32'(last_low), 32'd136);

    // Read-flagged frame is sent but must not change the register
    d0 = done_cnt;
    issue(1'b0, 7'd1, 8'h55);
    wait_done(d0, 1);
    check("rd_frame", 32'(last_frame), 32'h0155);
    check("rd_bits",  32'(last_bits),  32'd16);
    check("rd_reg1",  32'(regs[1]),    32'h0F);

    // Reset in the middle of a shifted frame
    d0 = done_cnt;
    issue(1'b1, 7'd3, 8'hFF);
    repeat (80) @(negedge clk);
    check("mid_sclk", 32'(SCLK), 32'(1'b1));
    check("mid_copi", 32'(COPI), 32'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("abort_ncs",   32'(nCS),       32'(1'b1));
    check("abort_sclk",  32'(SCLK),      32'(1'b0));
    check("abort_copi",  32'(COPI),      32'(1'b0));
    check("abort_busy",  32'(busy),      32'(1'b0));
    check("abort_ready", 32'(req_ready), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_back", 32'(req_ready), 32'(1'b1));
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_reg3", 32'(regs[3]), 32'h00);

    // Recovery frame after the abort
    d0 = done_cnt;
    issue(1'b1, 7'd3, 8'h3C);
    wait_done(d0, 1);
    check("rec_reg3", 32'(regs[3]), 32'h3C);
    check("rec_ncs_low", 32'(last_low), 32'd136);

`ifdef SPI_CTRL_ADDR_CHECK_EN
    // Out-of-range write is consumed without a frame
    d0 = done_cnt;
    f0 = frames_started;
    issue(1'b1, 7'd5, 8'h11);
    @(negedge clk);
    check("rej_err",   32'(err),       32'(1'b1));
    check("rej_ready", 32'(req_ready), 32'(1'b0));
    check("rej_ncs",   32'(nCS),       32'(1'b1));
    check("rej_busy",  32'(busy),      32'(1'b0));
    @(negedge clk);
    check("rej_err_clr",  32'(err),       32'(1'b0));
    check("rej_ready_bk", 32'(req_ready), 32'(1'b1));
    repeat (20) @(negedge clk);
    check("rej_no_frame", 32'(frames_started - f0), 32'd0);
    check("rej_no_done",  32'(done_cnt - d0), 32'd0);
    issue(1'b1, 7'd4, 8'h22);
    wait_done(d0, 1);
    check("rej_next_frame", 32'(last_frame), 32'h8422);
    check("rej_next_reg4",  32'(regs[4]),    32'h22);
    check("err_pulses", 32'(err_cnt), 32'd1);
`else
    check("err_pulses", 32'(err_cnt), 32'd0);
`endif

    // Idle must stay quiet
    repeat (30) @(negedge clk);
    check("idle_ncs",  32'(nCS),  32'(1'b1));
    check("idle_sclk", 32'(SCLK), 32'(1'b0));
    check("copi_stable_while_high", 32'(copi_bad), 32'd0);
    check("no_sclk_outside_cs",     32'(sclk_bad), 32'd0);
    check("done_with_ncs_rise",     32'(done_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
